writeback_unit: RTL and testbench

//   Write-back end of the pipelined datapath: accepts ALU results (rd, data, flags) from the EX/MEM

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/wb_fifo.sv | 77 +++++++
 rtl/writeback_unit.sv | 119 +++++++++++
 tb/tb_writeback_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared datapath constants and the write-back entry type.
package pipeline_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-back queue storage: pointer FIFO with per-entry address match vectors
// ordered by age (bit 0 = youngest) for the bypass network.
module wb_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [ADDR_W-1:0]            push_rd,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [ADDR_W-1:0]            head_rd,
  output logic [DATA_W-1:0]            head_data,
  output logic                         full,
  output logic                         empty,
  output logic [PTR_W:0]               count,
  input  logic [ADDR_W-1:0]            look_a,
  input  logic [ADDR_W-1:0]            look_b,
  output logic [DEPTH-1:0]             match_a,
  output logic [DEPTH-1:0]             match_b,
  output logic [DEPTH-1:0][DATA_W-1:0] age_data
);

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head_rd   = rd_mem[rd_ptr[PTR_W-1:0]];
  assign head_data = data_mem[rd_ptr[PTR_W-1:0]];

  // Flush simply catches the read pointer up, so stale slots are never live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      rd_mem[wr_ptr[PTR_W-1:0]]   <= push_rd;
      data_mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

  always_comb begin
    logic [PTR_W-1:0] slot;
    logic             live;
    slot     = '0;
    live     = 1'b0;
    match_a  = '0;
    match_b  = '0;
    age_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot        = wr_ptr[PTR_W-1:0] - PTR_W'(i + 1);
      live        = ((PTR_W + 1)'(i) < count);
      match_a[i]  = live && (rd_mem[slot] == look_a);
      match_b[i]  = live && (rd_mem[slot] == look_b);
      age_data[i] = data_mem[slot];
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Write-back unit: queues ALU results, drains one per cycle to the register file
// and forwards pending values. Optional overflow trap under macro WB_OVF_TRAP_EN.
module writeback_unit #(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_rd,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_ovf,
  input  logic                      flush,
  input  logic                      rf_busy,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic [ADDR_W-1:0]         fwd_rs_addr,
  input  logic [ADDR_W-1:0]         fwd_rt_addr,
  output logic                      fwd_rs_hit,
  output logic [DATA_W-1:0]         fwd_rs_data,
  output logic                      fwd_rt_hit,
  output logic [DATA_W-1:0]         fwd_rt_data,
  output logic [$clog2(DEPTH):0]    pending,
  output logic                      ovf_trap
);

  import pipeline_pkg::*;

  logic                         accept;
  logic                         enq;
  logic                         drain;
  logic                         full;
  logic                         empty;
  logic [ADDR_W-1:0]            head_rd;
  logic [DATA_W-1:0]            head_data;
  logic [DEPTH-1:0]             match_rs;
  logic [DEPTH-1:0]             match_rt;
  logic [DEPTH-1:0][DATA_W-1:0] age_data;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign drain    = !empty && !rf_busy && !flush;

`ifdef WB_OVF_TRAP_EN
  logic trap_q;

  assign enq      = accept && (in_rd != ADDR_W'(REG_ZERO)) && !in_ovf && !flush;
  assign ovf_trap = trap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 trap_q <= 1'b0;
    else if (accept && in_ovf)  trap_q <= 1'b1;
  end
`else
  logic unused_ovf;

  assign unused_ovf = in_ovf;
  assign enq        = accept && (in_rd != ADDR_W'(REG_ZERO)) && !flush;
  assign ovf_trap   = 1'b0;
`endif

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (enq),
    .push_rd   (in_rd),
    .push_data (in_data),
    .pop       (drain),
    .flush     (flush),
    .head_rd   (head_rd),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (pending),
    .look_a    (fwd_rs_addr),
    .look_b    (fwd_rt_addr),
    .match_a   (match_rs),
    .match_b   (match_rt),
    .age_data  (age_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= drain;
      if (drain) begin
        rf_waddr <= head_rd;
        rf_wdata <= head_data;
      end
    end
  end

  // Output stage is oldest; queue is scanned oldest->youngest so the youngest match wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] addr,
                                             input logic [DEPTH-1:0]  match);
    logic [DATA_W:0] res;
    res = '0;
    if (rf_we && (rf_waddr == addr)) res = {1'b1, rf_wdata};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!flush && match[i]) res = {1'b1, age_data[i]};
    end
    if (addr == ADDR_W'(REG_ZERO)) res = '0;
    return res;
  endfunction

  assign {fwd_rs_hit, fwd_rs_data} = lookup(fwd_rs_addr, match_rs);
  assign {fwd_rt_hit, fwd_rt_data} = lookup(fwd_rt_addr, match_rt);

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected register writes are queued at
// stimulus time and checked by a monitor whenever rf_we is seen.
module tb_writeback_unit;

  import pipeline_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic              in_ovf;
  logic              flush;
  logic              rf_busy;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] fwd_rs_addr;
  logic [ADDR_W-1:0] fwd_rt_addr;
  logic              fwd_rs_hit;
  logic [DATA_W-1:0] fwd_rs_data;
  logic              fwd_rt_hit;
  logic [DATA_W-1:0] fwd_rt_data;
  logic [2:0]        pending;
  logic              ovf_trap;

  wb_entry_t exp_q[$];
  int        n_compared = 0;
  int        n_failed   = 0;

`ifdef WB_OVF_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rd       (in_rd),
    .in_data     (in_data),
    .in_ovf      (in_ovf),
    .flush       (flush),
    .rf_busy     (rf_busy),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .fwd_rs_addr (fwd_rs_addr),
    .fwd_rt_addr (fwd_rt_addr),
    .fwd_rs_hit  (fwd_rs_hit),
    .fwd_rs_data (fwd_rs_data),
    .fwd_rt_hit  (fwd_rt_hit),
    .fwd_rt_data (fwd_rt_data),
    .pending     (pending),
    .ovf_trap    (ovf_trap)
  );

  always #5 clk = ~clk;

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_failed++;
        $display("[TB] FAIL unexpected_write: got rd=%0d data=%h, required none", rf_waddr, rf_wdata);
      end else begin
        wb_entry_t e;
        e = exp_q.pop_front();
        if (rf_waddr !== e.rd || rf_wdata !== e.data) begin
          n_failed++;
          $display("[TB] FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_waddr, rf_wdata, e.rd, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] rd,
                               input logic [DATA_W-1:0] data, input logic ovf);
    in_valid = v;
    in_rd    = rd;
    in_data  = data;
    in_ovf   = ovf;
  endtask

  task automatic sendResult(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data,
                            input logic ovf, input bit expect_write);
    applyStimulus(1'b1, rd, data, ovf);
    if (expect_write) exp_q.push_back(wb_entry_t'{rd: rd, data: data});
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    rf_busy     = 1'b0;
    fwd_rs_addr = '0;
    fwd_rt_addr = '0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    checkOutput("reset_pending",  32'(pending),  32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_rf_we",    32'(rf_we),    32'd0);
    checkOutput("reset_waddr",    32'(rf_waddr), 32'd0);
    checkOutput("reset_wdata",    rf_wdata,      32'd0);
    checkOutput("reset_trap",     32'(ovf_trap), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single result drains as one pulse
    sendResult(5'd3, 32'h0000_00A5, 1'b0, 1'b1);
    checkOutput("t1_pending", 32'(pending), 32'd1);
    tick();
    checkOutput("t1_we_high", 32'(rf_we),    32'd1);
    checkOutput("t1_waddr",   32'(rf_waddr), 32'd3);
    checkOutput("t1_wdata",   rf_wdata,      32'h0000_00A5);
    tick();
    checkOutput("t1_we_pulse", 32'(rf_we), 32'd0);

    // Back-pressure fills the queue, then drains in order
    rf_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sendResult(ADDR_W'(i), 32'h100 + 32'(i), 1'b0, 1'b1);
      checkOutput("t2_fill_pending", 32'(pending), 32'(i));
    end
    checkOutput("t2_ready_low", 32'(in_ready), 32'd0);
    sendResult(5'd5, 32'h105, 1'b0, 1'b0);
    checkOutput("t2_full_pending", 32'(pending), 32'd4);
    checkOutput("t2_no_write",     32'(rf_we),   32'd0);
    rf_busy = 1'b0;
    repeat (4) tick();
    checkOutput("t2_drained", 32'(pending), 32'd0);
    tick();
    checkOutput("t2_ready_back", 32'(in_ready), 32'd1);

    // Youngest pending value wins the bypass
    rf_busy = 1'b1;
    sendResult(5'd7, 32'd11, 1'b0, 1'b1);
    sendResult(5'd7, 32'd22, 1'b0, 1'b1);
    fwd_rs_addr = 5'd7;
    fwd_rt_addr = 5'd0;
    #1;
    checkOutput("t3_rs_hit",  32'(fwd_rs_hit), 32'd1);
    checkOutput("t3_rs_data", fwd_rs_data,     32'd22);
    checkOutput("t3_rt_zero", 32'(fwd_rt_hit), 32'd0);
    fwd_rt_addr = 5'd8;
    #1;
    checkOutput("t3_rt_miss", 32'(fwd_rt_hit), 32'd0);
    rf_busy = 1'b0;
    tick();
    checkOutput("t3_mid_data", fwd_rs_data, 32'd22);
    tick();
    checkOutput("t3_outstage_hit",  32'(fwd_rs_hit), 32'd1);
    checkOutput("t3_outstage_data", fwd_rs_data,     32'd22);
    tick();
    checkOutput("t3_gone", 32'(fwd_rs_hit), 32'd0);

    // Writes to r0 are accepted but dropped
    sendResult(5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checkOutput("t4_pending", 32'(pending), 32'd0);
    tick();
    checkOutput("t4_no_write", 32'(rf_we), 32'd0);

    // Flush beats a simultaneous push
    rf_busy = 1'b1;
    sendResult(5'd12, 32'hC, 1'b0, 1'b1);
    sendResult(5'd13, 32'hD, 1'b0, 1'b1);
    sendResult(5'd14, 32'hE, 1'b0, 1'b1);
    checkOutput("t5_queued", 32'(pending), 32'd3);
    flush = 1'b1;
    sendResult(5'd15, 32'hF, 1'b0, 1'b0);
    flush = 1'b0;
    exp_q.delete();
    checkOutput("t5_pending", 32'(pending), 32'd0);
    fwd_rs_addr = 5'd12;
    fwd_rt_addr = 5'd15;
    #1;
    checkOutput("t5_rs_nohit", 32'(fwd_rs_hit), 32'd0);
    checkOutput("t5_rt_nohit", 32'(fwd_rt_hit), 32'd0);
    rf_busy = 1'b0;
    tick();
    tick();
    checkOutput("t5_no_write", 32'(rf_we), 32'd0);

    // Overflowed result: trapped or written depending on the build
    sendResult(5'd9, 32'h99, 1'b1, !TRAP_ON);
    checkOutput("t6_trap", 32'(ovf_trap), 32'(TRAP_ON));
    tick();
    checkOutput("t6_write", 32'(rf_we), 32'(!TRAP_ON));
    tick();
    tick();
    checkOutput("t6_trap_sticky", 32'(ovf_trap), 32'(TRAP_ON));

    // Reset mid-operation discards queued entries and the trap
    rf_busy = 1'b1;
    sendResult(5'd20, 32'h20, 1'b0, 1'b0);
    sendResult(5'd21, 32'h21, 1'b0, 1'b0);
    checkOutput("t7_before_reset", 32'(pending), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("t7_pending", 32'(pending),  32'd0);
    checkOutput("t7_trap",    32'(ovf_trap), 32'd0);
    checkOutput("t7_rf_we",   32'(rf_we),    32'd0);
    tick();
    rst_n   = 1'b1;
    rf_busy = 1'b0;
    repeat (3) tick();
    checkOutput("t7_no_write", 32'(rf_we), 32'd0);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
